// File: rtl/alu_pkg.sv
// Shared ALU definitions for the shift datapath and its sequencer.
// Provides data/shamt/opcode width constants, the SLL/SRA opcode encodings,
// the sequencer state enumeration and a small opcode-classification helper.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 5;

  localparam logic [OP_W-1:0] OP_SLL = 5'b00100;
  localparam logic [OP_W-1:0] OP_SRA = 5'b00101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  // True for the opcodes the shared shifter can execute.
  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shifter.sv
// Shared 32-bit shift datapath (purely combinational).
// Ports:
//   data_i   [31:0] operand A
//   shamt_i  [4:0]  shift amount
//   op_i     [4:0]  ALU opcode (OP_SLL or OP_SRA)
//   result_o [31:0] shifted value, zero for unsupported opcodes
//   err_o           high when op_i is neither SLL nor SRA
module shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [OP_W-1:0]    op_i,
  output logic [DATA_W-1:0]  result_o,
  output logic               err_o
);

  logic signed [DATA_W-1:0] data_s;

  assign data_s = $signed(data_i);

  always_comb begin
    result_o = '0;
    err_o    = !is_shift_op(op_i);
    case (op_i)
      OP_SLL:  result_o = data_i << shamt_i;
      // Arithmetic shift replicates bit 31 into the vacated positions.
      OP_SRA:  result_o = data_s >>> shamt_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port sequencer/arbiter in front of the shared shifter.
// Accepts one shift request at a time from port 0 (ALU issue) or port 1
// (multdiv), latches its operands, evaluates them through a single shifter
// instance and returns a registered, ID-tagged result held until consumed.
//
// Configuration macro:
//   SHIFT_ARB_RR_EN  defined   -> round-robin arbitration on ties
//                    undefined -> fixed priority, port 0 always wins ties
//
// Ports:
//   clock                  rising-edge clock
//   reset_n                asynchronous active-low reset
//   req_valid  [1:0]       per-port request valid
//   req_ready  [1:0]       per-port accept (one-hot or zero, IDLE only)
//   req_data0/1 [31:0]     operand A per port
//   req_shamt0/1 [4:0]     shift amount per port
//   req_op0/1  [4:0]       opcode per port
//   rsp_valid              result available
//   rsp_ready              consumer accepts result
//   rsp_data   [31:0]      shift result
//   rsp_id                 port that issued the operation
//   rsp_err                opcode was neither SLL nor SRA
//   busy                   high whenever not IDLE
module shift_arbiter
  import alu_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [DATA_W-1:0]  req_data0,
  input  logic [DATA_W-1:0]  req_data1,
  input  logic [SHAMT_W-1:0] req_shamt0,
  input  logic [SHAMT_W-1:0] req_shamt1,
  input  logic [OP_W-1:0]    req_op0,
  input  logic [OP_W-1:0]    req_op1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_id,
  output logic               rsp_err,
  output logic               busy
);

  state_e state_q, state_d;

  // Latched operands feeding the shifter.
  logic [DATA_W-1:0]  data_q,  data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [OP_W-1:0]    op_q,    op_d;
  logic               id_q,    id_d;

  // Registered response.
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;
  logic               rsp_id_q,    rsp_id_d;
  logic               rsp_err_q,   rsp_err_d;

  logic [DATA_W-1:0]  sh_result;
  logic               sh_err;

  // Winning port for the current cycle; only meaningful when |req_valid.
  logic               win_id;
  logic               accept;

`ifdef SHIFT_ARB_RR_EN
  logic               last_grant_q, last_grant_d;
`endif

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  always_comb begin
    win_id = 1'b0;
    case (req_valid)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
`ifdef SHIFT_ARB_RR_EN
      // On a tie the port that was not granted last time wins.
      2'b11:   win_id = ~last_grant_q;
`else
      2'b11:   win_id = 1'b0;
`endif
      default: win_id = 1'b0;
    endcase
  end

  assign accept = (state_q == IDLE) && (|req_valid);

`ifdef SHIFT_ARB_RR_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = win_id;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Shared shifter, fed only from latched operands
  // ---------------------------------------------------------------------
  shifter u_shifter (
    .data_i   (data_q),
    .shamt_i  (shamt_q),
    .op_i     (op_q),
    .result_o (sh_result),
    .err_o    (sh_err)
  );

  // ---------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    shamt_d     = shamt_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[win_id] = 1'b1;
          id_d              = win_id;
          if (win_id) begin
            data_d  = req_data1;
            shamt_d = req_shamt1;
            op_d    = req_op1;
          end else begin
            data_d  = req_data0;
            shamt_d = req_shamt0;
            op_d    = req_op0;
          end
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = sh_result;
        rsp_err_d   = sh_err;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      shamt_q     <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      shamt_q     <= shamt_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef SHIFT_ARB_RR_EN
  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule
